// File: rtl/turn_signal_pkg.sv
// Shared types for the tail-light cluster: FSM states, arbitration side, lamp bundles
// and the lamp pattern decode used by the controller.
package turn_signal_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    L1     = 4'd1,
    L2     = 4'd2,
    L3     = 4'd3,
    R1     = 4'd4,
    R2     = 4'd5,
    R3     = 4'd6,
    HZ_ON  = 4'd7,
    HZ_OFF = 4'd8
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } lamp_t;

  typedef struct packed {
    lamp_t lt;
    lamp_t rt;
  } cluster_t;

  // Base sequence pattern for a state, then the brake overlay on the opposite/idle side.
  function automatic cluster_t lamp_decode(input state_t s, input logic brk);
    cluster_t c;
    c = '0;
    case (s)
      L1:      c.lt = lamp_t'(3'b100);
      L2:      c.lt = lamp_t'(3'b110);
      L3:      c.lt = lamp_t'(3'b111);
      R1:      c.rt = lamp_t'(3'b100);
      R2:      c.rt = lamp_t'(3'b110);
      R3:      c.rt = lamp_t'(3'b111);
      HZ_ON:   c    = '1;
      default: c    = '0;
    endcase
    if (brk) begin
      case (s)
        L1, L2, L3: c.rt = '1;
        R1, R2, R3: c.lt = '1;
        default:    c    = '1;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/turn_signal_ctrl_if.sv
// Driver-request and lamp-pin bundle between the cab switches and the tail-light controller.
interface turn_signal_ctrl_if;
  logic left_req;
  logic right_req;
  logic hazard_req;
  logic brake;
  logic la;
  logic lb;
  logic lc;
  logic ra;
  logic rb;
  logic rc;
  logic busy;
  logic tick;

  modport master (
    output left_req, right_req, hazard_req, brake,
    input  la, lb, lc, ra, rb, rc, busy, tick
  );

  modport slave (
    input  left_req, right_req, hazard_req, brake,
    output la, lb, lc, ra, rb, rc, busy, tick
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: counts 0..TICK_DIV-1 and strobes on the last count.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          last_c;

  assign last_c = (count_q == CW'(TICK_DIV - 1));
  assign tick_o = last_c;

  always_comb begin
    count_d = count_q + CW'(1);
    if (last_c) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/turn_signal_ctrl.sv
// Tail-light controller: latches turn requests, arbitrates left/right round-robin,
// gives hazard priority and overlays brake on registered lamp outputs.
module turn_signal_ctrl
  import turn_signal_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  turn_signal_ctrl_if.slave  bus
);

  state_t   state_q, state_d;
  side_t    last_side_q, last_side_d;
  logic     pend_l_q, pend_l_d;
  logic     pend_r_q, pend_r_d;
  logic     brake_q;
  cluster_t lamps_q;
  logic     tick;
  logic     l_eff, r_eff, in_hazard;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  // A request arriving in the tick cycle itself must still win dispatch.
  assign l_eff     = pend_l_q | bus.left_req;
  assign r_eff     = pend_r_q | bus.right_req;
  assign in_hazard = (state_q == HZ_ON) || (state_q == HZ_OFF);

  always_comb begin
    state_d     = state_q;
    last_side_d = last_side_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;

    if (!in_hazard) begin
      pend_l_d = l_eff;
      pend_r_d = r_eff;
    end

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (bus.hazard_req) begin
            state_d = HZ_ON;
          end else if ((l_eff && r_eff && (last_side_q == RIGHT)) || (l_eff && !r_eff)) begin
            state_d     = L1;
            last_side_d = LEFT;
            pend_l_d    = 1'b0;
          end else if (r_eff) begin
            state_d     = R1;
            last_side_d = RIGHT;
            pend_r_d    = 1'b0;
          end
        end
        L1:      state_d = bus.hazard_req ? HZ_ON : L2;
        L2:      state_d = bus.hazard_req ? HZ_ON : L3;
        L3:      state_d = bus.hazard_req ? HZ_ON : IDLE;
        R1:      state_d = bus.hazard_req ? HZ_ON : R2;
        R2:      state_d = bus.hazard_req ? HZ_ON : R3;
        R3:      state_d = bus.hazard_req ? HZ_ON : IDLE;
        HZ_ON:   state_d = bus.hazard_req ? HZ_OFF : IDLE;
        HZ_OFF:  state_d = bus.hazard_req ? HZ_ON : IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Hazard wipes any queued turn so nothing replays afterwards.
    if ((state_d == HZ_ON) && (state_q != HZ_ON)) begin
      pend_l_d = 1'b0;
      pend_r_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_side_q <= RIGHT;
      pend_l_q    <= 1'b0;
      pend_r_q    <= 1'b0;
      brake_q     <= 1'b0;
      lamps_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_side_q <= last_side_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      brake_q     <= bus.brake;
      lamps_q     <= lamp_decode(state_d, brake_q);
    end
  end

  assign bus.la   = lamps_q.lt.a;
  assign bus.lb   = lamps_q.lt.b;
  assign bus.lc   = lamps_q.lt.c;
  assign bus.ra   = lamps_q.rt.a;
  assign bus.rb   = lamps_q.rt.b;
  assign bus.rc   = lamps_q.rt.c;
  assign bus.busy = (state_q != IDLE);
  assign bus.tick = tick;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl with TICK_DIV=4; lamps viewed as {la,lb,lc,ra,rb,rc}.
module tb_turn_signal_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  turn_signal_ctrl_if bus ();

  turn_signal_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] lamps;
  assign lamps = {bus.la, bus.lb, bus.lc, bus.ra, bus.rb, bus.rc};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the negedge inside cycle c (cycle 0 = period where reset was released).
  task automatic at_cycle(input int c);
    while (cyc_n < c) begin
      @(negedge clk);
      cyc_n++;
    end
  endtask

  task automatic do_reset();
    bus.left_req   = 1'b0;
    bus.right_req  = 1'b0;
    bus.hazard_req = 1'b0;
    bus.brake      = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc_n = 0;
  endtask

  initial begin
    bus.left_req   = 1'b0;
    bus.right_req  = 1'b0;
    bus.hazard_req = 1'b0;
    bus.brake      = 1'b0;

    // Single left pulse, then simultaneous requests with last_side=LEFT -> right wins.
    do_reset();
    check("rst_lamps", 32'(lamps), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tick", 32'(bus.tick), 32'd0);
    at_cycle(1); bus.left_req = 1'b1;
    at_cycle(2); bus.left_req = 1'b0;
    check("t1_c2_tick", 32'(bus.tick), 32'd0);
    at_cycle(3);
    check("t1_c3_tick", 32'(bus.tick), 32'd1);
    check("t1_c3_lamps", 32'(lamps), 32'h00);
    at_cycle(4);
    check("t1_L1", 32'(lamps), 32'b100000);
    check("t1_L1_busy", 32'(bus.busy), 32'd1);
    at_cycle(8);  check("t1_L2", 32'(lamps), 32'b110000);
    at_cycle(12); check("t1_L3", 32'(lamps), 32'b111000);
    at_cycle(16);
    check("t1_idle", 32'(lamps), 32'h00);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);
    at_cycle(17); bus.left_req = 1'b1; bus.right_req = 1'b1;
    at_cycle(18); bus.left_req = 1'b0; bus.right_req = 1'b0;
    at_cycle(20); check("t1_rr_R1", 32'(lamps), 32'b000100);
    at_cycle(28); check("t1_rr_R3", 32'(lamps), 32'b000111);
    at_cycle(32); check("t1_rr_gap", 32'(lamps), 32'h00);
    at_cycle(36); check("t1_rr_L1", 32'(lamps), 32'b100000);

    // Both pulsed from reset (last_side=RIGHT) -> left first, then right.
    do_reset();
    at_cycle(1); bus.left_req = 1'b1; bus.right_req = 1'b1;
    at_cycle(2); bus.left_req = 1'b0; bus.right_req = 1'b0;
    at_cycle(4);  check("t2_L1", 32'(lamps), 32'b100000);
    at_cycle(12); check("t2_L3", 32'(lamps), 32'b111000);
    at_cycle(16);
    check("t2_gap", 32'(lamps), 32'h00);
    check("t2_gap_busy", 32'(bus.busy), 32'd0);
    at_cycle(20); check("t2_R1", 32'(lamps), 32'b000100);
    at_cycle(24); check("t2_R2", 32'(lamps), 32'b000110);
    at_cycle(28); check("t2_R3", 32'(lamps), 32'b000111);
    at_cycle(32); check("t2_done_busy", 32'(bus.busy), 32'd0);

    // Hazard during L2 aborts the left sequence.
    do_reset();
    at_cycle(1); bus.left_req = 1'b1;
    at_cycle(2); bus.left_req = 1'b0;
    at_cycle(9); bus.hazard_req = 1'b1;
    at_cycle(12); check("t3_hz_on", 32'(lamps), 32'b111111);
    at_cycle(16);
    check("t3_hz_off", 32'(lamps), 32'h00);
    check("t3_hz_off_busy", 32'(bus.busy), 32'd1);
    at_cycle(20); check("t3_hz_on2", 32'(lamps), 32'b111111);
    at_cycle(21); bus.hazard_req = 1'b0;
    at_cycle(22); check("t3_hold", 32'(lamps), 32'b111111);
    at_cycle(24);
    check("t3_idle", 32'(lamps), 32'h00);
    check("t3_idle_busy", 32'(bus.busy), 32'd0);
    at_cycle(28); check("t3_no_resume", 32'(lamps), 32'h00);

    // Brake during R2 lights the left side two edges later; brake in IDLE lights all.
    do_reset();
    at_cycle(1); bus.right_req = 1'b1;
    at_cycle(2); bus.right_req = 1'b0;
    at_cycle(8);
    check("t4_R2", 32'(lamps), 32'b000110);
    bus.brake = 1'b1;
    at_cycle(9);  check("t4_brk_lag", 32'(lamps), 32'b000110);
    at_cycle(10); check("t4_brk_R2", 32'(lamps), 32'b111110);
    at_cycle(12); check("t4_brk_R3", 32'(lamps), 32'b111111);
    at_cycle(16);
    check("t4_brk_idle", 32'(lamps), 32'b111111);
    check("t4_brk_idle_busy", 32'(bus.busy), 32'd0);
    bus.brake = 1'b0;
    at_cycle(17); check("t4_rel_lag", 32'(lamps), 32'b111111);
    at_cycle(18); check("t4_rel", 32'(lamps), 32'h00);

    // Asynchronous reset mid-L2, on a tick cycle, clears everything at once.
    do_reset();
    at_cycle(1); bus.left_req = 1'b1;
    at_cycle(2); bus.left_req = 1'b0;
    at_cycle(11);
    check("t5_pre_lamps", 32'(lamps), 32'b110000);
    check("t5_pre_tick", 32'(bus.tick), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_lamps", 32'(lamps), 32'h00);
    check("t5_async_busy", 32'(bus.busy), 32'd0);
    check("t5_async_tick", 32'(bus.tick), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc_n = 0;
    at_cycle(2); check("t5_c2_tick", 32'(bus.tick), 32'd0);
    at_cycle(3); check("t5_c3_tick", 32'(bus.tick), 32'd1);
    at_cycle(4);
    check("t5_no_resume", 32'(lamps), 32'h00);
    check("t5_no_resume_busy", 32'(bus.busy), 32'd0);

    // Right pulse during HZ_OFF is ignored after hazard drops.
    do_reset();
    at_cycle(1); bus.hazard_req = 1'b1;
    at_cycle(4); check("t6_hz_on", 32'(lamps), 32'b111111);
    at_cycle(8);
    check("t6_hz_off", 32'(lamps), 32'h00);
    bus.right_req = 1'b1;
    at_cycle(9); bus.right_req = 1'b0; bus.hazard_req = 1'b0;
    at_cycle(12);
    check("t6_idle", 32'(lamps), 32'h00);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    at_cycle(16);
    check("t6_no_right", 32'(lamps), 32'h00);
    check("t6_no_right_busy", 32'(bus.busy), 32'd0);

    // Request present only in the tick cycle still dispatches; cleared pend does not replay.
    do_reset();
    at_cycle(3); bus.left_req = 1'b1;
    at_cycle(4);
    bus.left_req = 1'b0;
    check("t7_tick_req", 32'(lamps), 32'b100000);
    at_cycle(16); check("t7_gap", 32'(lamps), 32'h00);
    at_cycle(20); check("t7_no_replay", 32'(lamps), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
